// File: rtl/wb_ram_responder.sv
// ---------------------------------------------------------------------------
// wb_ram_responder
//
// Wishbone classic (B3) responder that terminates a wide user bus with an
// on-chip RAM model. It inserts a programmable number of wait states between
// capturing a request and terminating it. This lets a bus initiator be
// exercised without a real memory controller behind it. It also keeps
// saturating counters of completed writes, completed reads and error
// terminations.
//
// Ports
//   user_clk   in   sole clock, rising edge
//   user_rst   in   asynchronous active-high reset
//   wb_cyc     in   bus cycle active; dropping it during WAIT aborts the request
//   wb_stb     in   strobe; a request is wb_cyc & wb_stb seen in IDLE
//   wb_we      in   1 = write, 0 = read
//   wb_adr     in   word address
//   wb_dat_w   in   write data
//   wb_sel     in   byte-lane enables, bit i covers data bits 8i+7:8i
//   wb_dat_r   out  read data, held until the next successful read
//   wb_ack     out  one-cycle normal termination
//   wb_err     out  one-cycle error termination (address beyond RAM)
//   busy       out  high while a request is in flight (WAIT or RESP)
//   wr_count   out  completed writes, saturating
//   rd_count   out  completed reads, saturating
//   err_count  out  error terminations, saturating
// ---------------------------------------------------------------------------
module wb_ram_responder #(
  parameter int DATA_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 25,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                    user_clk,
  input  logic                    user_rst,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [ADDR_WIDTH-1:0]   wb_adr,
  input  logic [DATA_WIDTH-1:0]   wb_dat_w,
  input  logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic [DATA_WIDTH-1:0]   wb_dat_r,
  output logic                    wb_ack,
  output logic                    wb_err,
  output logic                    busy,
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count,
  output logic [15:0]             err_count
);

  localparam int          SEL_WIDTH = DATA_WIDTH / 8;
  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_wait_cnt;
  logic [3:0]              w_next_wait_cnt;

  logic [ADDR_WIDTH-1:0]   r_adr;
  logic                    r_we;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [SEL_WIDTH-1:0]    r_sel;
  logic                    r_oor;
  logic [DATA_WIDTH-1:0]   r_dat_r;
  logic [15:0]             r_wr_count;
  logic [15:0]             r_rd_count;
  logic [15:0]             r_err_count;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_req;
  logic                    w_capture;
  logic                    w_enter_resp;
  logic [ADDR_WIDTH-1:0]   w_adr;
  logic                    w_we;
  logic [DATA_WIDTH-1:0]   w_dat;
  logic [SEL_WIDTH-1:0]    w_sel;
  logic                    w_oor;
  logic [DEPTH_LOG2-1:0]   w_idx;

  assign w_req = wb_cyc & wb_stb;

  // With zero wait states the request is captured and completed on the same
  // edge, so the RAM access has to see the live bus rather than the capture
  // registers. In every other case the registers already hold the request.
  assign w_adr = (r_state == ST_IDLE) ? wb_adr   : r_adr;
  assign w_we  = (r_state == ST_IDLE) ? wb_we    : r_we;
  assign w_dat = (r_state == ST_IDLE) ? wb_dat_w : r_dat;
  assign w_sel = (r_state == ST_IDLE) ? wb_sel   : r_sel;
  assign w_idx = w_adr[DEPTH_LOG2-1:0];

  // Any set address bit above the RAM index means the word is not backed.
  generate
    if (DEPTH_LOG2 < ADDR_WIDTH) begin : g_oor
      assign w_oor = |w_adr[ADDR_WIDTH-1:DEPTH_LOG2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  // State register and wait-state counter.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
    end
  end

  // Next-state logic. The counter is loaded with the number of wait cycles
  // and the last WAIT cycle is the one that sees a count of 1. This gives
  // exactly WAIT_STATES cycles in WAIT. Losing wb_cyc in WAIT takes priority
  // over completing, so an abort never produces a termination.
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_capture       = 1'b0;
    w_enter_resp    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_capture       = 1'b1;
          w_next_wait_cnt = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            w_next_state = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc) begin
          w_next_state = ST_IDLE;
        end else if (r_wait_cnt <= 4'd1) begin
          w_next_wait_cnt = 4'd0;
          w_next_state    = ST_RESP;
          w_enter_resp    = 1'b1;
        end else begin
          w_next_wait_cnt = r_wait_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Request capture, read data, error flag and statistics. All completion
  // effects happen on the edge that enters RESP, so they are visible during
  // the termination cycle. An error leaves the read data untouched.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      r_adr       <= '0;
      r_we        <= 1'b0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_oor       <= 1'b0;
      r_dat_r     <= '0;
      r_wr_count  <= 16'd0;
      r_rd_count  <= 16'd0;
      r_err_count <= 16'd0;
    end else begin
      if (w_capture) begin
        r_adr <= wb_adr;
        r_we  <= wb_we;
        r_dat <= wb_dat_w;
        r_sel <= wb_sel;
      end
      if (w_enter_resp) begin
        r_oor <= w_oor;
        if (w_oor) begin
          if (r_err_count != CNT_MAX) r_err_count <= r_err_count + 16'd1;
        end else if (w_we) begin
          if (r_wr_count != CNT_MAX) r_wr_count <= r_wr_count + 16'd1;
        end else begin
          r_dat_r <= r_mem[w_idx];
          if (r_rd_count != CNT_MAX) r_rd_count <= r_rd_count + 16'd1;
        end
      end
    end
  end

  // RAM array. Its contents survive reset. The write is gated by reset so
  // that a request caught while reset is high can never land in memory.
  always_ff @(posedge user_clk) begin
    if (w_enter_resp && w_we && !w_oor && !user_rst) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (w_sel[i]) r_mem[w_idx][8*i +: 8] <= w_dat[8*i +: 8];
      end
    end
  end

  assign wb_ack    = (r_state == ST_RESP) && !r_oor;
  assign wb_err    = (r_state == ST_RESP) &&  r_oor;
  assign busy      = (r_state != ST_IDLE);
  assign wb_dat_r  = r_dat_r;
  assign wr_count  = r_wr_count;
  assign rd_count  = r_rd_count;
  assign err_count = r_err_count;

endmodule
